victim_cache_ctrl: RTL and testbench

VICTIM_CACHE_CTRL -- requirements
Module: victim_cache_ctrl

---
 rtl/vc_pkg.sv | 20 ++
 rtl/victim_cache_ctrl_if.sv | 55 +++++
 rtl/victim_cache_ctrl.sv | 127 ++++++++++++
 tb/tb_victim_cache_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// Shared definitions for the victim cache controller: FSM state encoding and
// default geometry.
package vc_pkg;

  localparam int VC_TAG_WIDTH = 4;
  localparam int VC_NUM_WAYS  = 4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_P_LOOK = 4'd1,
    ST_P_RES  = 4'd2,
    ST_P_INV  = 4'd3,
    ST_I_RD   = 4'd4,
    ST_I_CHK  = 4'd5,
    ST_I_WB   = 4'd6,
    ST_I_WR   = 4'd7,
    ST_I_DIRTY = 4'd8
  } vc_state_e;

endpackage

// File: rtl/victim_cache_ctrl_if.sv
// Bundle of the probe, insert, writeback and tag-store signals of the victim
// cache controller. The slave modport is the controller's own view.
interface victim_cache_ctrl_if #(
  parameter int TAG_WIDTH = vc_pkg::VC_TAG_WIDTH,
  parameter int NUM_WAYS  = vc_pkg::VC_NUM_WAYS
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                 probe_req;
  logic [TAG_WIDTH-1:0] probe_tag;
  logic                 probe_ack;
  logic                 probe_hit;
  logic [WAY_W-1:0]     probe_way;

  logic                 ins_req;
  logic [TAG_WIDTH-1:0] ins_tag;
  logic                 ins_dirty;
  logic                 ins_ack;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [TAG_WIDTH-1:0] wb_tag;
  logic [WAY_W-1:0]     wb_way;

  logic                 ts_write_en;
  logic                 ts_read_en;
  logic                 ts_lookup_en;
  logic                 ts_valid_clear;
  logic                 ts_dirty_set;
  logic [TAG_WIDTH-1:0] ts_tag;
  logic [WAY_W-1:0]     ts_way;

  logic                 ts_hit;
  logic [WAY_W-1:0]     ts_hit_way;
  logic                 ts_valid_read;
  logic                 ts_dirty_read;
  logic [TAG_WIDTH-1:0] ts_tag_read;

  modport slave (
    input  probe_req, probe_tag, ins_req, ins_tag, ins_dirty, wb_ready,
           ts_hit, ts_hit_way, ts_valid_read, ts_dirty_read, ts_tag_read,
    output probe_ack, probe_hit, probe_way, ins_ack, wb_valid, wb_tag, wb_way,
           ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set,
           ts_tag, ts_way
  );

  modport master (
    output probe_req, probe_tag, ins_req, ins_tag, ins_dirty, wb_ready,
           ts_hit, ts_hit_way, ts_valid_read, ts_dirty_read, ts_tag_read,
    input  probe_ack, probe_hit, probe_way, ins_ack, wb_valid, wb_tag, wb_way,
           ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set,
           ts_tag, ts_way
  );

endinterface

// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: sequences probe (lookup/invalidate) and insert
// (read victim, optional dirty writeback, write) commands to an external tag store.
module victim_cache_ctrl
  import vc_pkg::*;
#(
  parameter int TAG_WIDTH = VC_TAG_WIDTH,
  parameter int NUM_WAYS  = VC_NUM_WAYS
) (
  input logic                clk,
  input logic                rst,
  victim_cache_ctrl_if.slave bus
);

  localparam int WAY_W = $clog2(NUM_WAYS);

  localparam logic [3:0] IDLE    = ST_IDLE;
  localparam logic [3:0] P_LOOK  = ST_P_LOOK;
  localparam logic [3:0] P_RES   = ST_P_RES;
  localparam logic [3:0] P_INV   = ST_P_INV;
  localparam logic [3:0] I_RD    = ST_I_RD;
  localparam logic [3:0] I_CHK   = ST_I_CHK;
  localparam logic [3:0] I_WB    = ST_I_WB;
  localparam logic [3:0] I_WR    = ST_I_WR;
  localparam logic [3:0] I_DIRTY = ST_I_DIRTY;

  logic [3:0]           state;
  logic [3:0]           state_nxt;
  logic [WAY_W-1:0]     rr_ptr;
  logic [WAY_W-1:0]     hit_way_r;
  logic [TAG_WIDTH-1:0] wb_tag_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (bus.ins_ack) rr_ptr <= rr_ptr + 1'b1;
    end
  end

  // Operand capture only; every output using these is gated by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == P_RES) hit_way_r <= bus.ts_hit_way;
    if (state == I_CHK) wb_tag_r  <= bus.ts_tag_read;
  end

  always_comb begin
    state_nxt          = state;
    bus.probe_ack      = 1'b0;
    bus.probe_hit      = 1'b0;
    bus.probe_way      = '0;
    bus.ins_ack        = 1'b0;
    bus.wb_valid       = 1'b0;
    bus.wb_tag         = '0;
    bus.wb_way         = '0;
    bus.ts_write_en    = 1'b0;
    bus.ts_read_en     = 1'b0;
    bus.ts_lookup_en   = 1'b0;
    bus.ts_valid_clear = 1'b0;
    bus.ts_dirty_set   = 1'b0;
    bus.ts_tag         = '0;
    bus.ts_way         = '0;
    unique case (state)
      IDLE: begin
        if (bus.probe_req)    state_nxt = P_LOOK;
        else if (bus.ins_req) state_nxt = I_RD;
      end
      P_LOOK: begin
        bus.ts_lookup_en = 1'b1;
        bus.ts_tag       = bus.probe_tag;
        state_nxt        = P_RES;
      end
      P_RES: begin
        if (bus.ts_hit) begin
          state_nxt = P_INV;
        end else begin
          bus.probe_ack = 1'b1;
          state_nxt     = IDLE;
        end
      end
      // Hit lines are exclusive: the line moves back to L1, so drop it here.
      P_INV: begin
        bus.ts_valid_clear = 1'b1;
        bus.ts_way         = hit_way_r;
        bus.probe_ack      = 1'b1;
        bus.probe_hit      = 1'b1;
        bus.probe_way      = hit_way_r;
        state_nxt          = IDLE;
      end
      I_RD: begin
        bus.ts_read_en = 1'b1;
        bus.ts_way     = rr_ptr;
        state_nxt      = I_CHK;
      end
      I_CHK: begin
        state_nxt = (bus.ts_valid_read && bus.ts_dirty_read) ? I_WB : I_WR;
      end
      I_WB: begin
        bus.wb_valid = 1'b1;
        bus.wb_tag   = wb_tag_r;
        bus.wb_way   = rr_ptr;
        if (bus.wb_ready) state_nxt = I_WR;
      end
      // The tag store writes the line clean; a dirty victim needs a second strobe.
      I_WR: begin
        bus.ts_write_en = 1'b1;
        bus.ts_tag      = bus.ins_tag;
        bus.ts_way      = rr_ptr;
        if (bus.ins_dirty) begin
          state_nxt = I_DIRTY;
        end else begin
          bus.ins_ack = 1'b1;
          state_nxt   = IDLE;
        end
      end
      I_DIRTY: begin
        bus.ts_dirty_set = 1'b1;
        bus.ts_way       = rr_ptr;
        bus.ins_ack      = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Randomized bench for victim_cache_ctrl: behavioural tag store plus a
// transaction-level reference of victim contents and replacement order.
module tb_victim_cache_ctrl;
  import vc_pkg::*;

  localparam int TW = 4;
  localparam int NW = 4;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic rst;
  logic store_clr;

  always #5 clk = ~clk;

  victim_cache_ctrl_if #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) bus ();

  victim_cache_ctrl #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Tag store: results registered one cycle after the strobe.
  logic [TW-1:0] st_tag   [NW];
  logic          st_valid [NW];
  logic          st_dirty [NW];

  always @(posedge clk) begin
    if (store_clr) begin
      for (int i = 0; i < NW; i++) begin
        st_valid[i] <= 1'b0;
        st_dirty[i] <= 1'b0;
        st_tag[i]   <= '0;
      end
      bus.ts_hit        <= 1'b0;
      bus.ts_hit_way    <= '0;
      bus.ts_valid_read <= 1'b0;
      bus.ts_dirty_read <= 1'b0;
      bus.ts_tag_read   <= '0;
    end else begin
      if (bus.ts_lookup_en) begin
        bus.ts_hit     <= 1'b0;
        bus.ts_hit_way <= '0;
        for (int i = NW - 1; i >= 0; i--)
          if (st_valid[i] && st_tag[i] == bus.ts_tag) begin
            bus.ts_hit     <= 1'b1;
            bus.ts_hit_way <= WW'(i);
          end
      end
      if (bus.ts_read_en) begin
        bus.ts_valid_read <= st_valid[bus.ts_way];
        bus.ts_dirty_read <= st_dirty[bus.ts_way];
        bus.ts_tag_read   <= st_tag[bus.ts_way];
      end
      if (bus.ts_write_en) begin
        st_tag[bus.ts_way]   <= bus.ts_tag;
        st_valid[bus.ts_way] <= 1'b1;
        st_dirty[bus.ts_way] <= 1'b0;
      end
      if (bus.ts_valid_clear) st_valid[bus.ts_way] <= 1'b0;
      if (bus.ts_dirty_set)   st_dirty[bus.ts_way] <= 1'b1;
    end
  end

  int strobe_viol = 0;
  always @(negedge clk) begin
    if (!rst && (32'(bus.ts_write_en) + 32'(bus.ts_read_en) + 32'(bus.ts_lookup_en) +
                 32'(bus.ts_valid_clear) + 32'(bus.ts_dirty_set) > 1))
      strobe_viol++;
  end

  logic [31:0] outs;
  assign outs = {9'd0, bus.probe_ack, bus.probe_hit, bus.probe_way, bus.ins_ack,
                 bus.wb_valid, bus.wb_tag, bus.wb_way, bus.ts_write_en, bus.ts_read_en,
                 bus.ts_lookup_en, bus.ts_valid_clear, bus.ts_dirty_set, bus.ts_tag,
                 bus.ts_way};

  // Reference: what the victim cache should hold and which way is next to go.
  logic [TW-1:0] ref_tag   [NW];
  logic          ref_valid [NW];
  logic          ref_dirty [NW];
  int            ref_rr;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < NW; i++) begin
      ref_tag[i]   = '0;
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
    ref_rr = 0;
  endtask

  function automatic int ref_find(input logic [TW-1:0] t);
    int w = -1;
    for (int i = 0; i < NW; i++)
      if (ref_valid[i] && ref_tag[i] == t) w = i;
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    bus.probe_req = 1'b0;
    bus.ins_req   = 1'b0;
    bus.wb_ready  = 1'b0;
    rst       = 1'b1;
    store_clr = 1'b1;
    #1 check_val("reset_outs", outs, 32'd0);
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    store_clr = 1'b0;
    ref_clear();
    @(negedge clk);
  endtask

  task automatic do_probe(input logic [TW-1:0] t);
    int exp_way, lat;
    bit got;
    logic hit_o, clr_o;
    logic [WW-1:0] way_o, clr_way;
    exp_way = ref_find(t);
    lat = 0; got = 1'b0;
    hit_o = 1'b0; clr_o = 1'b0; way_o = '0; clr_way = '0;
    bus.probe_tag = t;
    bus.probe_req = 1'b1;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.probe_ack) begin
        got = 1'b1;
        hit_o = bus.probe_hit; way_o = bus.probe_way;
        clr_o = bus.ts_valid_clear; clr_way = bus.ts_way;
      end
    end
    bus.probe_req = 1'b0;
    check_val("probe_ack", 32'(got), 32'd1);
    if (exp_way >= 0) begin
      check_val("probe_hit_lat", 32'(lat), 32'd3);
      check_val("probe_hit", 32'(hit_o), 32'd1);
      check_val("probe_way", 32'(way_o), 32'(exp_way));
      check_val("probe_clr", 32'(clr_o), 32'd1);
      check_val("probe_clr_way", 32'(clr_way), 32'(exp_way));
      ref_valid[exp_way] = 1'b0;
    end else begin
      check_val("probe_miss_lat", 32'(lat), 32'd2);
      check_val("probe_miss_hit", 32'(hit_o), 32'd0);
      check_val("probe_miss_clr", 32'(clr_o), 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic do_insert(input logic [TW-1:0] t, input logic d, input int wb_delay);
    int w, lat, wb_cyc, wr_cnt, ds_cnt, exp_lat;
    bit got, exp_wb;
    logic [TW-1:0] exp_wbtag, wr_tag;
    logic [WW-1:0] wr_way, ds_way;
    w = ref_rr;
    exp_wb = ref_valid[w] && ref_dirty[w];
    exp_wbtag = ref_tag[w];
    lat = 0; wb_cyc = 0; wr_cnt = 0; ds_cnt = 0; got = 1'b0;
    wr_tag = '0; wr_way = '0; ds_way = '0;
    bus.ins_tag = t; bus.ins_dirty = d; bus.ins_req = 1'b1; bus.wb_ready = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.ts_write_en) begin wr_cnt++; wr_way = bus.ts_way; wr_tag = bus.ts_tag; end
      if (bus.ts_dirty_set) begin ds_cnt++; ds_way = bus.ts_way; end
      if (bus.wb_valid) begin
        wb_cyc++;
        check_val("wb_tag", 32'(bus.wb_tag), 32'(exp_wbtag));
        check_val("wb_way", 32'(bus.wb_way), 32'(w));
        if (wb_cyc > wb_delay) bus.wb_ready = 1'b1;
      end
      if (bus.ins_ack) got = 1'b1;
    end
    bus.ins_req = 1'b0; bus.wb_ready = 1'b0;
    exp_lat = 3 + int'(d) + (exp_wb ? wb_delay + 1 : 0);
    check_val("ins_ack", 32'(got), 32'd1);
    check_val("ins_lat", 32'(lat), 32'(exp_lat));
    check_val("wb_cycles", 32'(wb_cyc), exp_wb ? 32'(wb_delay + 1) : 32'd0);
    check_val("ts_write_cnt", 32'(wr_cnt), 32'd1);
    check_val("ts_write_way", 32'(wr_way), 32'(w));
    check_val("ts_write_tag", 32'(wr_tag), 32'(t));
    check_val("ts_dirty_cnt", 32'(ds_cnt), 32'(d));
    if (d) check_val("ts_dirty_way", 32'(ds_way), 32'(w));
    ref_tag[w] = t; ref_valid[w] = 1'b1; ref_dirty[w] = d;
    ref_rr = (ref_rr + 1) % NW;
    @(negedge clk);
  endtask

  task automatic do_both(input logic [TW-1:0] pt, input logic [TW-1:0] it, input logic d);
    int pw, w, cyc, p_cyc, i_cyc;
    bit exp_wb;
    logic p_hit;
    pw = ref_find(pt);
    if (pw >= 0) ref_valid[pw] = 1'b0;
    w = ref_rr;
    exp_wb = ref_valid[w] && ref_dirty[w];
    cyc = 0; p_cyc = -1; i_cyc = -1; p_hit = 1'b0;
    bus.probe_tag = pt; bus.ins_tag = it; bus.ins_dirty = d;
    bus.probe_req = 1'b1; bus.ins_req = 1'b1; bus.wb_ready = 1'b1;
    while (i_cyc < 0 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.probe_ack && p_cyc < 0) begin
        p_cyc = cyc; p_hit = bus.probe_hit; bus.probe_req = 1'b0;
      end
      if (bus.ins_ack) begin i_cyc = cyc; bus.ins_req = 1'b0; end
    end
    bus.probe_req = 1'b0; bus.ins_req = 1'b0; bus.wb_ready = 1'b0;
    check_val("both_probe_lat", 32'(p_cyc), (pw >= 0) ? 32'd3 : 32'd2);
    check_val("both_probe_hit", 32'(p_hit), (pw >= 0) ? 32'd1 : 32'd0);
    check_val("both_ins_lat", 32'(i_cyc),
              32'(p_cyc + 1 + 3 + int'(d) + (exp_wb ? 1 : 0)));
    ref_tag[w] = it; ref_valid[w] = 1'b1; ref_dirty[w] = d;
    ref_rr = (ref_rr + 1) % NW;
    @(negedge clk);
  endtask

  task automatic reset_during_wb(input logic [TW-1:0] t);
    int cyc;
    bit seen_wb, seen_ack;
    cyc = 0; seen_wb = 1'b0; seen_ack = 1'b0;
    bus.ins_tag = t; bus.ins_dirty = 1'b1; bus.ins_req = 1'b1; bus.wb_ready = 1'b0;
    while (!seen_wb && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.wb_valid) seen_wb = 1'b1;
      if (bus.ins_ack) seen_ack = 1'b1;
    end
    check_val("rst_wb_reached", 32'(seen_wb), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_val("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check_val("rst_async_outs", outs, 32'd0);
    @(negedge clk);
    if (bus.ins_ack) seen_ack = 1'b1;
    bus.ins_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_no_ack", 32'(seen_ack), 32'd0);
    ref_rr = 0;
    @(negedge clk);
  endtask

  initial begin
    bus.probe_req = 1'b0; bus.probe_tag = '0;
    bus.ins_req = 1'b0; bus.ins_tag = '0; bus.ins_dirty = 1'b0;
    bus.wb_ready = 1'b0;
    rst = 1'b1; store_clr = 1'b1;
    ref_clear();
    repeat (3) @(negedge clk);
    check_val("reset_state", outs, 32'd0);
    rst = 1'b0; store_clr = 1'b0;
    @(negedge clk);

    // Five dirty inserts: the fifth evicts dirty tag 0x1 from way 0.
    for (int i = 1; i <= 5; i++) do_insert(TW'(i), 1'b1, 3);
    reset_during_wb(4'h6);
    do_insert(4'h7, 1'b0, 1);

    do_reset();
    do_insert(4'hA, 1'b0, 0);
    do_probe(4'hA);
    do_probe(4'hF);

    do_both(4'hC, 4'hC, 1'b0);
    do_both(4'h3, 4'h3, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [TW-1:0] t;
      t = TW'($urandom_range(0, 15));
      do_probe(t);
      if ($urandom_range(0, 3) != 0)
        do_insert(t, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < NW; i++) begin
      check_val("store_valid", 32'(st_valid[i]), 32'(ref_valid[i]));
      if (ref_valid[i]) begin
        check_val("store_tag", 32'(st_tag[i]), 32'(ref_tag[i]));
        check_val("store_dirty", 32'(st_dirty[i]), 32'(ref_dirty[i]));
      end
    end
    check_val("strobe_onehot", 32'(strobe_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
